decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
// Registered, parametrised instruction-decode pipeline stage between fetch and register read. Decodes one
// instruction per cycle into datapath controls, with valid/ready handshakes, a 2-entry skid buffer, flush,
// illegal-opcode flagging, sticky halt and sign-extended immediate/offset at datapath width.
// PARAMETERS
// RW  3   register-address width; IR fields RS/RT/RD are RW bits each
// FW  3   FUNCT/FS width
// DW  16  datapath width of IMM/OFF outputs (DW >= RW+FW)
// (derived) INST_W = 4+3*RW+FW; IW = RW+FW = raw immediate width
// PORTS
// clk        in   1       clock, all state on rising edge
// rst_n      in   1       synchronous reset, active low
// in_valid   in   1       fetch presents instruction
// in_inst    in   INST_W  {OP[4],RS,RT,RD,FUNCT}; raw IMM = {RD,FUNCT}
// in_ready   out  1       stage can accept
// flush      in   1       drop all held entries (taken branch)
// out_valid  out  1       decoded bundle valid
// out_ready  in   1       downstream accepts
// DR,SA,SB   out  RW      dest/source register addresses
// IMM,OFF    out  DW      sign-extended immediate / branch offset
// MB,MD,LD,MW out 1       B-mux imm, mem-to-reg, reg write, mem write
// FS         out  FW      ALU function
// BS         out  3       branch select; 3'b100 = no branch
// HALT       out  1       bundle is HALT
// ILL        out  1       bundle came from undefined opcode
// halted     out  1       stage has accepted HALT (sticky)
// BEHAVIOUR
// - Reset (rst_n=0 at edge): buffer empty, out_valid=0, halted=0, in_ready=0 during reset; all bundle outputs 0
//   except BS=3'b100. rst_n mid-transfer discards all entries; nothing is replayed.
// - Decode table (unlisted fields: DR/SA/SB=0, MB/MD/LD/MW=0, FS=0, BS=100, OFF=0, IMM=sext(raw)):
//   0000 NOP; HALT=1 iff FUNCT==1 | 0010 DR=RT SA=RS MB MD LD | 0100 SA=RS SB=RT MB MW
//   0101 DR=RT SA=RS MB LD | 0110 as 0101, FS=5 | 0111 as 0101, FS=6
//   1000/1001 SA=RS SB=RT FS=1 BS=000/001 OFF=sext(raw) | 1010/1011 SA=RS MB BS=010/011 OFF=sext(raw) IMM=0
//   1111 DR=RD SA=RS SB=RT FS=FUNCT LD | others: NOP encoding with ILL=1.
//   FS constants 1,5,6 zero-extended to FW. Sign extension replicates raw bit IW-1 to DW.
// - Decode is combinational on in_inst; the decoded bundle is what gets stored. Latency 1 cycle:
//   inst accepted at edge N appears on outputs with out_valid=1 after edge N when buffer was empty.
// - Handshake: transfer in when in_valid&&in_ready; out when out_valid&&out_ready. Outputs stable while
//   out_valid&&!out_ready. in_ready = !halted && count<2 (registered, no comb path from out_ready).
// - Buffer FSM count EMPTY(0)/ONE(1)/FULL(2), FIFO order: 0->1 on accept; 1->2 accept w/o drain;
//   1->1 accept+drain; 1->0 drain; 2->1 drain (no accept possible). Simultaneous accept+drain at ONE keeps ONE.
// - flush=1: next state EMPTY, out_valid=0; same-cycle in_valid is dropped (flush wins); halted unchanged.
// - Halt FSM RUN->HALTED when a HALT instruction is accepted (not when issued). HALTED: in_ready=0; entries
//   already held still drain, including the HALT bundle itself. Leaves HALTED only on reset. Flush
//   discarding the HALT bundle still leaves halted=1.
// - ILL bundles flow like NOPs; no trap, no stall.
// TESTING
// 1 Reset: rst_n=0 two cycles with in_valid=1 -> out_valid=0, in_ready=0, BS=100; release -> in_ready=1.
// 2 Stream, out_ready=1: 16'h5A45 (ADDI RS=5 RT=1 raw=6'h05) -> next cycle DR=1 SA=5 MB=1 LD=1 IMM=16'h0005;
//   16'h8A7E (BEQ, raw 6'h3E) -> OFF=16'hFFFE, BS=000, FS=1; one bundle per cycle, order preserved.
// 3 Backpressure: out_ready=0, issue 3 insts -> two accepted, in_ready=0 after second, outputs hold first;
//   out_ready=1 -> drains in order, third accepted.
// 4 Flush with FULL buffer and in_valid=1 -> next cycle out_valid=0, count 0, flushed and incoming insts never appear.
// 5 HALT 16'h0001 then ADD 16'hF2D0 same stream -> HALT bundle out with HALT=1, halted=1, in_ready=0,
//   ADD never accepted until rst_n pulse.
// 6 Opcode 4'b0011 (16'h3FFF) -> ILL=1, LD=MW=0, BS=100; RW=4,FW=4,DW=32 build: 1111 inst FS=FUNCT, IMM 32-bit sext.

Source files
------------

// File: rtl/decode_stage_if.sv
// -----------------------------------------------------------------------------
// decode_stage_if
// Purpose : bundles the fetch-side and register-read-side handshakes of the
//           decode stage, together with the decoded control bundle.
// Signals : in_valid/in_inst/in_ready   - instruction handshake from fetch
//           out_valid/out_ready         - bundle handshake to register read
//           DR,SA,SB                    - dest/source register addresses
//           IMM,OFF                     - sign-extended immediate / offset
//           MB,MD,LD,MW                 - B-mux imm, mem-to-reg, reg wr, mem wr
//           FS                          - ALU function
//           BS                          - branch select (3'b100 = none)
//           HALT, ILL                   - halt bundle, undefined opcode
// Modports: slave  - the decode stage itself
//           master - the surrounding fetch / downstream environment
// -----------------------------------------------------------------------------
interface decode_stage_if #(
    parameter int RW = 3,
    parameter int FW = 3,
    parameter int DW = 16
);
    localparam int INST_W = 4 + 3 * RW + FW;

    logic              in_valid;
    logic [INST_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [RW-1:0]     DR;
    logic [RW-1:0]     SA;
    logic [RW-1:0]     SB;
    logic [DW-1:0]     IMM;
    logic [DW-1:0]     OFF;
    logic              MB;
    logic              MD;
    logic              LD;
    logic              MW;
    logic [FW-1:0]     FS;
    logic [2:0]        BS;
    logic              HALT;
    logic              ILL;

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid,
        output DR, SA, SB, IMM, OFF, MB, MD, LD, MW, FS, BS, HALT, ILL
    );

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid,
        input  DR, SA, SB, IMM, OFF, MB, MD, LD, MW, FS, BS, HALT, ILL
    );
endinterface

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Purpose : registered instruction-decode stage between fetch and register
//           read. Decodes one instruction per cycle into datapath controls and
//           holds up to two decoded bundles in a FIFO-ordered skid buffer.
//           Supports flush (taken branch), illegal-opcode flagging and a
//           sticky halt that stops further acceptance until reset.
// Ports   : clk     - clock, all state on rising edge
//           rst_n   - synchronous reset, active low
//           flush   - drop every held bundle and any same-cycle instruction
//           halted  - a HALT instruction has been accepted (sticky)
//           dec     - decode_stage_if.slave: handshakes + decoded bundle
// Instruction layout: {OP[3:0], RS, RT, RD, FUNCT}; raw immediate = {RD, FUNCT}
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int RW = 3,
    parameter int FW = 3,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    output logic          halted,
    decode_stage_if.slave dec
);
    localparam int INST_W = 4 + 3 * RW + FW;
    localparam int IW     = RW + FW;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } cnt_e;

    typedef struct packed {
        logic [RW-1:0] dr;
        logic [RW-1:0] sa;
        logic [RW-1:0] sb;
        logic [DW-1:0] imm;
        logic [DW-1:0] off;
        logic          mb;
        logic          md;
        logic          ld;
        logic          mw;
        logic [FW-1:0] fs;
        logic [2:0]    bs;
        logic          halt;
        logic          ill;
    } bundle_t;

    function automatic logic [DW-1:0] sext(input logic [IW-1:0] raw);
        logic [DW-1:0] r;
        r         = {DW{raw[IW-1]}};
        r[IW-1:0] = raw;
        return r;
    endfunction

    function automatic bundle_t nop_bundle();
        bundle_t b;
        b    = '0;
        b.bs = 3'b100;
        return b;
    endfunction

    function automatic bundle_t decode(input logic [INST_W-1:0] inst);
        bundle_t       b;
        logic [3:0]    op;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [FW-1:0] funct;
        logic [IW-1:0] raw;
        op    = inst[INST_W-1 -: 4];
        rs    = inst[3*RW+FW-1 -: RW];
        rt    = inst[2*RW+FW-1 -: RW];
        rd    = inst[RW+FW-1 -: RW];
        funct = inst[FW-1:0];
        raw   = {rd, funct};
        b     = nop_bundle();
        b.imm = sext(raw);
        case (op)
            4'b0000: b.halt = (funct == FW'(1));
            4'b0010: begin
                b.dr = rt; b.sa = rs; b.mb = 1'b1; b.md = 1'b1; b.ld = 1'b1;
            end
            4'b0100: begin
                b.sa = rs; b.sb = rt; b.mb = 1'b1; b.mw = 1'b1;
            end
            4'b0101, 4'b0110, 4'b0111: begin
                b.dr = rt; b.sa = rs; b.mb = 1'b1; b.ld = 1'b1;
                if (op == 4'b0110) b.fs = FW'(5);
                if (op == 4'b0111) b.fs = FW'(6);
            end
            // Compare branches: ALU subtracts, low opcode bit picks the condition.
            4'b1000, 4'b1001: begin
                b.sa = rs; b.sb = rt; b.fs = FW'(1);
                b.bs = {2'b00, op[0]}; b.off = sext(raw);
            end
            4'b1010, 4'b1011: begin
                b.sa = rs; b.mb = 1'b1;
                b.bs = {2'b01, op[0]}; b.off = sext(raw); b.imm = '0;
            end
            4'b1111: begin
                b.dr = rd; b.sa = rs; b.sb = rt; b.fs = funct; b.ld = 1'b1;
            end
            default: b.ill = 1'b1;
        endcase
        return b;
    endfunction

    cnt_e    cnt_q;
    bundle_t head_q;
    bundle_t tail_q;
    logic    halted_q;
    logic    in_ready_q;

    bundle_t dec_d;
    logic    accept;
    logic    drain;
    logic    full_d;
    logic    halted_d;

    assign dec_d  = decode(dec.in_inst);
    // Flush wins over a same-cycle incoming instruction.
    assign accept = dec.in_valid && in_ready_q && !flush;
    assign drain  = (cnt_q != EMPTY) && dec.out_ready;

    // Next-cycle occupancy of two and next-cycle halt state drive the
    // registered in_ready, so out_ready never reaches in_ready combinationally.
    assign full_d   = ((cnt_q == ONE) && accept && !drain) ||
                      ((cnt_q == FULL) && !drain);
    assign halted_d = halted_q || (accept && dec_d.halt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= EMPTY;
            head_q     <= nop_bundle();
            tail_q     <= nop_bundle();
            halted_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else if (flush) begin
            cnt_q      <= EMPTY;
            in_ready_q <= !halted_q;
        end else begin
            case (cnt_q)
                EMPTY: begin
                    if (accept) begin
                        head_q <= dec_d;
                        cnt_q  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        head_q <= dec_d;
                    end else if (accept) begin
                        tail_q <= dec_d;
                        cnt_q  <= FULL;
                    end else if (drain) begin
                        cnt_q  <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        head_q <= tail_q;
                        cnt_q  <= ONE;
                    end
                end
                default: cnt_q <= EMPTY;
            endcase
            halted_q   <= halted_d;
            in_ready_q <= !halted_d && !full_d;
        end
    end

    assign halted        = halted_q;
    assign dec.in_ready  = in_ready_q;
    assign dec.out_valid = (cnt_q != EMPTY);
    assign dec.DR        = head_q.dr;
    assign dec.SA        = head_q.sa;
    assign dec.SB        = head_q.sb;
    assign dec.IMM       = head_q.imm;
    assign dec.OFF       = head_q.off;
    assign dec.MB        = head_q.mb;
    assign dec.MD        = head_q.md;
    assign dec.LD        = head_q.ld;
    assign dec.MW        = head_q.mw;
    assign dec.FS        = head_q.fs;
    assign dec.BS        = head_q.bs;
    assign dec.HALT      = head_q.halt;
    assign dec.ILL       = head_q.ill;
endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush;
    logic flush_b;
    logic halted;
    logic halted_b;
    int   errors = 0;
    int   checks = 0;

    decode_stage_if #(.RW(3), .FW(3), .DW(16)) a_if ();
    decode_stage_if #(.RW(4), .FW(4), .DW(32)) b_if ();

    decode_stage #(.RW(3), .FW(3), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .halted(halted), .dec(a_if)
    );

    decode_stage #(.RW(4), .FW(4), .DW(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b), .halted(halted_b), .dec(b_if)
    );

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference decode for the default build, packed as
    // {DR,SA,SB,IMM,OFF,MB,MD,LD,MW,FS,BS,HALT,ILL}.
    function automatic logic [52:0] model(input logic [15:0] i);
        logic [3:0]  op;
        logic [2:0]  rs, rt, rd, fn, dr, sa, sb, fs, bs;
        logic [15:0] se, imm, off;
        logic        mb, md, ld, mw, h, il;
        op = i[15:12]; rs = i[11:9]; rt = i[8:6]; rd = i[5:3]; fn = i[2:0];
        se = {{10{i[5]}}, i[5:0]};
        dr = 0; sa = 0; sb = 0; fs = 0; bs = 3'b100; imm = se; off = 0;
        mb = 0; md = 0; ld = 0; mw = 0; h = 0; il = 0;
        case (op)
            4'h0: h = (fn == 3'd1);
            4'h2: begin dr = rt; sa = rs; mb = 1; md = 1; ld = 1; end
            4'h4: begin sa = rs; sb = rt; mb = 1; mw = 1; end
            4'h5: begin dr = rt; sa = rs; mb = 1; ld = 1; end
            4'h6: begin dr = rt; sa = rs; mb = 1; ld = 1; fs = 3'd5; end
            4'h7: begin dr = rt; sa = rs; mb = 1; ld = 1; fs = 3'd6; end
            4'h8: begin sa = rs; sb = rt; fs = 3'd1; bs = 3'b000; off = se; end
            4'h9: begin sa = rs; sb = rt; fs = 3'd1; bs = 3'b001; off = se; end
            4'hA: begin sa = rs; mb = 1; bs = 3'b010; off = se; imm = 0; end
            4'hB: begin sa = rs; mb = 1; bs = 3'b011; off = se; imm = 0; end
            4'hF: begin dr = rd; sa = rs; sb = rt; fs = fn; ld = 1; end
            default: il = 1;
        endcase
        return {dr, sa, sb, imm, off, mb, md, ld, mw, fs, bs, h, il};
    endfunction

    logic [52:0] act_a;
    assign act_a = {a_if.DR, a_if.SA, a_if.SB, a_if.IMM, a_if.OFF, a_if.MB, a_if.MD,
                    a_if.LD, a_if.MW, a_if.FS, a_if.BS, a_if.HALT, a_if.ILL};

    // Scoreboard: inputs only change at posedge+1, so the negedge view is what
    // the next rising edge will act on.
    logic [52:0] sbq[$];
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (a_if.out_valid && a_if.out_ready) begin
                if (sbq.size() == 0) check_eq("sb_underflow", 128'(sbq.size()), 128'd1);
                else check_eq("bundle", act_a, sbq.pop_front());
            end
            if (flush) sbq.delete();
            else if (a_if.in_valid && a_if.in_ready) sbq.push_back(model(a_if.in_inst));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] inst);
        logic took;
        took = 1'b0;
        a_if.in_valid = 1'b1;
        a_if.in_inst  = inst;
        for (int n = 0; n < 50 && !took; n++) begin
            took = a_if.in_ready && !flush;
            tick();
        end
        check_eq("send_accept", took, 1'b1);
        a_if.in_valid = 1'b0;
    endtask

    logic [15:0] stream [12] = '{16'h2A45, 16'h4A45, 16'h6C8B, 16'h7C8B, 16'h9A7E, 16'hAA41,
                                 16'hBA7F, 16'hF2D0, 16'h0002, 16'hFFFF, 16'hC123, 16'h3FFF};

    initial begin
        // Reset with a pending instruction
        rst_n = 0; flush = 0; flush_b = 0;
        a_if.in_valid = 1; a_if.in_inst = 16'h5A45; a_if.out_ready = 1;
        b_if.in_valid = 0; b_if.in_inst = '0; b_if.out_ready = 1;
        tick(); tick();
        check_eq("rst_out_valid", a_if.out_valid, 1'b0);
        check_eq("rst_in_ready", a_if.in_ready, 1'b0);
        check_eq("rst_bs", a_if.BS, 3'b100);
        check_eq("rst_imm", a_if.IMM, 16'h0);
        check_eq("rst_halted", halted, 1'b0);
        a_if.in_valid = 0; rst_n = 1;
        tick();
        check_eq("rel_in_ready", a_if.in_ready, 1'b1);

        // Streaming with out_ready=1
        a_if.in_valid = 1; a_if.in_inst = 16'h5A45;
        tick();
        check_eq("addi_valid", a_if.out_valid, 1'b1);
        check_eq("addi_dr", a_if.DR, 3'd1);
        check_eq("addi_sa", a_if.SA, 3'd5);
        check_eq("addi_mb_ld", {a_if.MB, a_if.LD}, 2'b11);
        check_eq("addi_imm", a_if.IMM, 16'h0005);
        a_if.in_inst = 16'h8A7E;
        tick();
        check_eq("beq_off", a_if.OFF, 16'hFFFE);
        check_eq("beq_bs", a_if.BS, 3'b000);
        check_eq("beq_fs", a_if.FS, 3'd1);
        foreach (stream[k]) begin
            a_if.in_inst = stream[k];
            tick();
            check_eq("stream_valid", a_if.out_valid, 1'b1);
        end
        check_eq("ill_flag", a_if.ILL, 1'b1);
        check_eq("ill_ld_mw", {a_if.LD, a_if.MW}, 2'b00);
        check_eq("ill_bs", a_if.BS, 3'b100);
        a_if.in_valid = 0;
        tick(); tick();
        check_eq("stream_idle", a_if.out_valid, 1'b0);

        // Backpressure: two accepted, third waits
        a_if.out_ready = 0;
        a_if.in_valid = 1; a_if.in_inst = 16'h5A45; tick();
        a_if.in_inst = 16'h6C8B; tick();
        check_eq("bp_in_ready", a_if.in_ready, 1'b0);
        check_eq("bp_valid", a_if.out_valid, 1'b1);
        a_if.in_inst = 16'h7C8B;
        tick(); tick();
        check_eq("bp_hold_dr", a_if.DR, 3'd1);
        check_eq("bp_hold_imm", a_if.IMM, 16'h0005);
        check_eq("bp_still_full", a_if.in_ready, 1'b0);
        a_if.out_ready = 1;
        send(16'h7C8B);
        tick(); tick();
        check_eq("bp_drained", a_if.out_valid, 1'b0);

        // Flush with a full buffer and an incoming instruction
        a_if.out_ready = 0;
        send(16'h5A45); send(16'h6C8B);
        check_eq("fl_full", a_if.in_ready, 1'b0);
        a_if.in_valid = 1; a_if.in_inst = 16'h4A45; flush = 1;
        tick();
        flush = 0; a_if.in_valid = 0;
        check_eq("fl_valid", a_if.out_valid, 1'b0);
        check_eq("fl_in_ready", a_if.in_ready, 1'b1);
        a_if.out_ready = 1;
        repeat (3) tick();
        check_eq("fl_quiet", a_if.out_valid, 1'b0);
        send(16'h2A45);
        tick();

        // HALT followed by ADD
        send(16'h0001);
        check_eq("halt_flag", a_if.HALT, 1'b1);
        check_eq("halt_valid", a_if.out_valid, 1'b1);
        check_eq("halt_sticky", halted, 1'b1);
        check_eq("halt_in_ready", a_if.in_ready, 1'b0);
        a_if.in_valid = 1; a_if.in_inst = 16'hF2D0;
        repeat (4) begin
            tick();
            check_eq("halt_blocked", a_if.in_ready, 1'b0);
        end
        check_eq("halt_empty", a_if.out_valid, 1'b0);
        check_eq("halt_held", halted, 1'b1);
        rst_n = 0; tick(); rst_n = 1; tick();
        check_eq("halt_cleared", halted, 1'b0);
        tick();
        a_if.in_valid = 0;
        check_eq("add_dr", a_if.DR, 3'd2);
        check_eq("add_srcs", {a_if.SA, a_if.SB}, {3'd1, 3'd3});
        check_eq("add_ld", a_if.LD, 1'b1);
        tick();

        // Flush discarding a held HALT bundle keeps halted
        a_if.out_ready = 0;
        send(16'h0001);
        check_eq("fh_halted", halted, 1'b1);
        flush = 1; tick(); flush = 0;
        check_eq("fh_sticky", halted, 1'b1);
        check_eq("fh_valid", a_if.out_valid, 1'b0);
        check_eq("fh_in_ready", a_if.in_ready, 1'b0);
        rst_n = 0; tick(); rst_n = 1; tick();
        a_if.out_ready = 1;

        // Wide build: RW=4 FW=4 DW=32
        b_if.in_valid = 1; b_if.in_inst = 20'hF12A5;
        tick();
        check_eq("w_fs", b_if.FS, 4'd5);
        check_eq("w_imm", b_if.IMM, 32'hFFFFFFA5);
        check_eq("w_regs", {b_if.DR, b_if.SA, b_if.SB}, {4'hA, 4'h1, 4'h2});
        check_eq("w_ld", b_if.LD, 1'b1);
        b_if.in_inst = 20'h53412;
        tick();
        b_if.in_valid = 0;
        check_eq("w_addi_imm", b_if.IMM, 32'h00000012);
        check_eq("w_addi_regs", {b_if.DR, b_if.SA}, {4'h4, 4'h3});
        tick(); tick();

        check_eq("sb_drained", 128'(sbq.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
